// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the 16-bit datapath: fetch/decode/execute/mem/writeback
// sequencing with a memory-ready handshake and an optional wait watchdog.
module mc_control_unit #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [2:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_sel,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);
    // Memory handshake: in FETCH/MEMRD/MEMWR the request is held every cycle;
    // the access completes in the cycle mem_ready=1 and the FSM leaves the state.
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REXE, S_RWB, S_IEXE, S_IWB, S_BEQ, S_JUMP
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0, OP_ADDI = 4'd1, OP_LW = 4'd2,
                           OP_SW = 4'd3, OP_BEQ = 4'd4, OP_J = 4'd5;
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          waiting, timeout;

    // The branch decision is made in the datapath; zero is not needed here.
    logic unused_zero;
    assign unused_zero = zero;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;
        timeout = (WAIT_LIMIT != 0) && waiting && (wait_cnt == LIMIT);
        // Saturate so an unlimited wait never wraps the counter.
        if (!waiting || timeout)          wait_cnt_nxt = '0;
        else if (wait_cnt != {CW{1'b1}})  wait_cnt_nxt = wait_cnt + CW'(1);
        else                              wait_cnt_nxt = wait_cnt;
    end

    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_sel       = 3'b000;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (timeout) begin
                        mem_timeout = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE:     state_nxt = S_REXE;
                        OP_ADDI:      state_nxt = S_IEXE;
                        OP_LW, OP_SW: state_nxt = S_MEMADR;
                        OP_BEQ:       state_nxt = S_BEQ;
                        OP_J:         state_nxt = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            state_nxt  = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_nxt = S_MEMWB;
                    end else if (timeout) begin
                        mem_timeout = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end else if (timeout) begin
                        mem_timeout = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_REXE: begin
                    alu_src_a = 1'b1;
                    alu_sel   = func;
                    state_nxt = S_RWB;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_IEXE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = S_IWB;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    alu_sel       = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    instr_done    = 1'b1;
                    state_nxt     = S_FETCH;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: every cycle's full control word is compared
// against a hand-derived expected word.
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [2:0] func = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_sel;
    logic [3:0] state_dbg;
    logic [21:0] ctrl;

    int n_checks = 0;
    int n_errors = 0;

    mc_control_unit #(.WAIT_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_sel(alu_sel), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign ctrl = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                   ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                   alu_sel, instr_done, illegal_op, mem_timeout};

    function automatic logic [21:0] cw(
        input logic pw, input logic pwc, input logic [1:0] psrc, input logic iord,
        input logic mr, input logic mw, input logic irw, input logic rw,
        input logic [1:0] rdst, input logic [1:0] m2r, input logic sa,
        input logic [1:0] sb, input logic [2:0] alu, input logic done,
        input logic ill, input logic to);
        return {pw, pwc, psrc, iord, mr, mw, irw, rw, rdst, m2r, sa, sb, alu, done, ill, to};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs, let outputs settle, compare, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] op, input logic [2:0] fn,
                       input logic rdy, input logic [21:0] exp);
        opcode    = op;
        func      = fn;
        mem_ready = rdy;
        zero      = 1'(($urandom_range(0, 1)));
        #1;
        check(tag, {10'd0, ctrl}, {10'd0, exp});
        @(posedge clk);
        #1;
    endtask

    logic [21:0] e_zero, e_fetch_r, e_fetch_w, e_fetch_to, e_dec, e_dec_ill;
    logic [21:0] e_rexe0, e_rexe6, e_rwb, e_memadr, e_memrd, e_memrd_to, e_memwb;
    logic [21:0] e_memwr_w, e_memwr_r, e_iexe, e_iwb, e_beq, e_jump;

    initial begin
        e_zero     = '0;
        e_fetch_r  = cw(1, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0);
        e_fetch_w  = cw(0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0);
        e_fetch_to = cw(0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 3'b000, 0, 0, 1);
        e_dec      = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0);
        e_dec_ill  = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 3'b000, 0, 1, 0);
        e_rexe0    = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0, 0, 0);
        e_rexe6    = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b110, 0, 0, 0);
        e_rwb      = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0);
        e_memadr   = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0);
        e_memrd    = cw(0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
        e_memrd_to = cw(0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1);
        e_memwb    = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 3'b000, 1, 0, 0);
        e_memwr_w  = cw(0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
        e_memwr_r  = cw(0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0);
        e_iexe     = cw(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0);
        e_iwb      = cw(0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0);
        e_beq      = cw(0, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 3'b001, 1, 0, 0);
        e_jump     = cw(1, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0);

        @(posedge clk);
        #1;
        cyc("rst_a", 4'd3, 3'd0, 1'b1, e_zero);
        cyc("rst_b", 4'd2, 3'd0, 1'b1, e_zero);
        rst = 1'b0;

        cyc("add_fetch", 4'd0, 3'd0, 1'b1, e_fetch_r);
        cyc("add_dec",   4'd0, 3'd0, 1'b0, e_dec);
        cyc("add_exe",   4'd0, 3'd0, 1'b1, e_rexe0);
        cyc("add_wb",    4'd0, 3'd0, 1'b0, e_rwb);

        cyc("r6_fetch", 4'd0, 3'd6, 1'b1, e_fetch_r);
        cyc("r6_dec",   4'd0, 3'd6, 1'b1, e_dec);
        cyc("r6_exe",   4'd0, 3'd6, 1'b1, e_rexe6);
        cyc("r6_wb",    4'd0, 3'd6, 1'b1, e_rwb);

        cyc("addi_fetch", 4'd1, 3'd0, 1'b1, e_fetch_r);
        cyc("addi_dec",   4'd1, 3'd0, 1'b1, e_dec);
        cyc("addi_exe",   4'd1, 3'd0, 1'b1, e_iexe);
        cyc("addi_wb",    4'd1, 3'd0, 1'b1, e_iwb);

        // Ready arrives exactly when the count hits the limit: access completes.
        cyc("lw_fetch",  4'd2, 3'd0, 1'b1, e_fetch_r);
        cyc("lw_dec",    4'd2, 3'd0, 1'b1, e_dec);
        cyc("lw_adr",    4'd2, 3'd0, 1'b1, e_memadr);
        cyc("lw_rd_w1",  4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lw_rd_w2",  4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lw_rd_w3",  4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lw_rd_rdy", 4'd2, 3'd0, 1'b1, e_memrd);
        cyc("lw_wb",     4'd2, 3'd0, 1'b0, e_memwb);

        cyc("sw_fetch", 4'd3, 3'd0, 1'b1, e_fetch_r);
        cyc("sw_dec",   4'd3, 3'd0, 1'b1, e_dec);
        cyc("sw_adr",   4'd3, 3'd0, 1'b1, e_memadr);
        cyc("sw_wr",    4'd3, 3'd0, 1'b1, e_memwr_r);

        cyc("beq_fetch", 4'd4, 3'd0, 1'b1, e_fetch_r);
        cyc("beq_dec",   4'd4, 3'd0, 1'b1, e_dec);
        cyc("beq_exe",   4'd4, 3'd0, 1'b1, e_beq);

        cyc("j_fetch", 4'd5, 3'd0, 1'b1, e_fetch_r);
        cyc("j_dec",   4'd5, 3'd0, 1'b1, e_dec);
        cyc("j_exe",   4'd5, 3'd0, 1'b1, e_jump);

        cyc("ill_fetch", 4'hF, 3'd0, 1'b1, e_fetch_r);
        cyc("ill_dec",   4'hF, 3'd0, 1'b1, e_dec_ill);

        // Back in FETCH straight after the illegal opcode; then the fetch watchdog.
        cyc("to_w1",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("to_w2",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("to_w3",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("to_hit", 4'd5, 3'd0, 1'b0, e_fetch_to);
        cyc("re_w1",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("re_w2",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("re_w3",  4'd5, 3'd0, 1'b0, e_fetch_w);
        cyc("re_rdy", 4'd5, 3'd0, 1'b1, e_fetch_r);
        cyc("re_dec", 4'd5, 3'd0, 1'b1, e_dec);
        cyc("re_j",   4'd5, 3'd0, 1'b1, e_jump);

        cyc("lwto_fetch", 4'd2, 3'd0, 1'b1, e_fetch_r);
        cyc("lwto_dec",   4'd2, 3'd0, 1'b1, e_dec);
        cyc("lwto_adr",   4'd2, 3'd0, 1'b1, e_memadr);
        cyc("lwto_w1",    4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lwto_w2",    4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lwto_w3",    4'd2, 3'd0, 1'b0, e_memrd);
        cyc("lwto_hit",   4'd2, 3'd0, 1'b0, e_memrd_to);
        cyc("lwto_back",  4'd2, 3'd0, 1'b0, e_fetch_w);
        cyc("lwto_rdy",   4'd4, 3'd0, 1'b1, e_fetch_r);
        cyc("lwto_dec2",  4'd4, 3'd0, 1'b1, e_dec);
        cyc("lwto_beq",   4'd4, 3'd0, 1'b1, e_beq);

        cyc("swr_fetch", 4'd3, 3'd0, 1'b1, e_fetch_r);
        cyc("swr_dec",   4'd3, 3'd0, 1'b1, e_dec);
        cyc("swr_adr",   4'd3, 3'd0, 1'b1, e_memadr);
        cyc("swr_wait",  4'd3, 3'd0, 1'b0, e_memwr_w);
        rst = 1'b1;
        cyc("swr_rst",   4'd3, 3'd0, 1'b1, e_zero);
        rst = 1'b0;
        cyc("swr_after", 4'd3, 3'd0, 1'b0, e_fetch_w);
        cyc("swr_rdy",   4'd3, 3'd0, 1'b1, e_fetch_r);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
